mult_control_n: RTL and testbench

- Parametrised control unit for an N-bit add-shift multiplier datapath (registers X:A:B, B = multiplier, M = B[0], S = multiplicand).
- Sequences clear, WIDTH add/shift iterations, and run-once handshake.
- Counter-driven; width-independent.
- Adds a signed/unsigned mode, busy/done status, and an explicit Load_B strobe.

---
 rtl/mult_control_n_pkg.sv | 16 +
 rtl/mult_control_n_if.sv | 28 ++
 rtl/mult_control_n_iter_counter.sv | 26 ++
 rtl/mult_control_n.sv | 119 +++++++++++
 tb/tb_mult_control_n.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/mult_control_n_pkg.sv
// Shared types and constants for the add-shift multiplier controller.
package mult_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLEAR = 3'd1,
      ADD   = 3'd2,
      SHIFT = 3'd3,
      HOLD  = 3'd4
   } mult_state_t;

   // Sub_Add encoding seen by the datapath adder
   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/mult_control_n_if.sv
// Handshake/strobe bundle between the multiplier controller and its datapath.
// master: the side requesting multiplies and supplying M (datapath/host).
// slave : the controller itself.
interface mult_control_n_if;

   logic Run;
   logic ClearA_LoadB;
   logic M;
   logic Signed_Mode;
   logic Clear_A;
   logic Load_B;
   logic Add_En;
   logic Shift_En;
   logic Sub_Add;
   logic Busy;
   logic Done;

   modport master (
      output Run, ClearA_LoadB, M, Signed_Mode,
      input  Clear_A, Load_B, Add_En, Shift_En, Sub_Add, Busy, Done
   );

   modport slave (
      input  Run, ClearA_LoadB, M, Signed_Mode,
      output Clear_A, Load_B, Add_En, Shift_En, Sub_Add, Busy, Done
   );

endinterface

// File: rtl/mult_control_n_iter_counter.sv
// Iteration counter: cleared at the start of a multiply, stepped once per
// non-final SHIFT. It never wraps because the controller stops at WIDTH-1.
module iter_counter #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] count,
   output logic             last
);

   // Count register: synchronous clear has priority over increment
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (inc) begin
         count <= count + CNT_W'(1);
      end
   end

   assign last = (count == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/mult_control_n.sv
// Control unit for an N-bit add-shift multiplier (X:A:B, M = B[0]).
// Sequence: CLEAR, WIDTH x (ADD, SHIFT), then HOLD until Run drops.
module mult_control_n #(
   parameter int unsigned WIDTH = 8
) (
   input logic             Clk,
   input logic             Reset,
   mult_control_n_if.slave bus
);

   import mult_pkg::*;

   localparam int unsigned CNT_W = $clog2(WIDTH);

   mult_state_t      state_q;
   mult_state_t      state_d;
   logic             mode_q;
   logic [CNT_W-1:0] count;
   logic             last;
   logic             cnt_clr;
   logic             cnt_inc;

   logic clear_a;
   logic load_b;
   logic add_en;
   logic shift_en;
   logic sub_add;
   logic busy;
   logic done;

   iter_counter #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_iter_counter (
      .clk   (Clk),
      .rst   (Reset),
      .clr   (cnt_clr),
      .inc   (cnt_inc),
      .count (count),
      .last  (last)
   );

   // Next-state decode; unused encodings fall back to IDLE
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.Run) state_d = CLEAR;
         CLEAR:   state_d = ADD;
         ADD:     state_d = SHIFT;
         SHIFT:   state_d = last ? HOLD : ADD;
         HOLD:    if (!bus.Run) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State register and sign mode latched once at start
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= IDLE;
         mode_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && bus.Run) begin
            mode_q <= bus.Signed_Mode;
         end
      end
   end

   // Output and counter-control decode; everything defaults low
   always_comb begin
      clear_a  = 1'b0;
      load_b   = 1'b0;
      add_en   = 1'b0;
      shift_en = 1'b0;
      sub_add  = OP_ADD;
      busy     = 1'b0;
      done     = 1'b0;
      cnt_clr  = 1'b0;
      cnt_inc  = 1'b0;
      case (state_q)
         IDLE: begin
            // Run wins over a simultaneous ClearA_LoadB request
            if (!bus.Run && bus.ClearA_LoadB) begin
               clear_a = 1'b1;
               load_b  = 1'b1;
            end
         end
         CLEAR: begin
            clear_a = 1'b1;
            busy    = 1'b1;
            cnt_clr = 1'b1;
         end
         ADD: begin
            busy   = 1'b1;
            add_en = bus.M;
            // Two's-complement: the sign bit of the multiplier has negative weight
            if (mode_q && count == CNT_W'(WIDTH - 1)) sub_add = OP_SUB;
         end
         SHIFT: begin
            shift_en = 1'b1;
            busy     = 1'b1;
            cnt_inc  = !last;
         end
         HOLD: begin
            done = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.Clear_A  = clear_a;
   assign bus.Load_B   = load_b;
   assign bus.Add_En   = add_en;
   assign bus.Shift_En = shift_en;
   assign bus.Sub_Add  = sub_add;
   assign bus.Busy     = busy;
   assign bus.Done     = done;

endmodule

// File: tb/tb_mult_control_n.sv
// Bench for mult_control_n: three widths (8, 16, 2) share one stimulus stream;
// a per-width phase model predicts every output each cycle via a scoreboard.
module tb_mult_control_n;

   typedef logic [6:0]      ov_t;   // {Clear_A, Load_B, Add_En, Shift_En, Sub_Add, Busy, Done}
   typedef logic [2:0][6:0] exp_t;

   logic clk = 1'b0;
   logic rst;
   logic run, cl, m, sm;

   always #5 clk = ~clk;

   mult_control_n_if if8 ();
   mult_control_n_if if16 ();
   mult_control_n_if if2 ();

   mult_control_n #(.WIDTH(8))  dut8  (.Clk(clk), .Reset(rst), .bus(if8));
   mult_control_n #(.WIDTH(16)) dut16 (.Clk(clk), .Reset(rst), .bus(if16));
   mult_control_n #(.WIDTH(2))  dut2  (.Clk(clk), .Reset(rst), .bus(if2));

   int   wid [3] = '{8, 16, 2};
   int   ph  [3];             // 0 idle, 1 clear, 2..2w+1 add/shift, 2w+2 hold
   logic mode[3];
   exp_t sb[$];

   int checks   = 0;
   int failures = 0;
   int tick_no  = 0;
   int run_tick = 0;
   int n_clr[3], n_ld[3], n_add[3], n_shift[3], n_sub[3], sub_at[3], first_done[3];
   logic [7:0] add_mask;
   logic [7:0] bpat = 8'b1010_0101;

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      checks++;
      assert (o === e) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   function automatic ov_t model_out(int k);
      ov_t r = '0;
      int  w = wid[k];
      if (ph[k] == 0) begin
         r[6] = !run && cl;
         r[5] = !run && cl;
      end else if (ph[k] == 1) begin
         r[6] = 1'b1;
         r[1] = 1'b1;
      end else if (ph[k] <= 2 * w + 1) begin
         r[1] = 1'b1;
         if (ph[k] % 2 == 0) begin
            r[4] = m;
            r[2] = mode[k] && (ph[k] == 2 * w);
         end else begin
            r[3] = 1'b1;
         end
      end else begin
         r[0] = 1'b1;
      end
      return r;
   endfunction

   function automatic ov_t get_obs(int k);
      case (k)
         0: return {if8.Clear_A, if8.Load_B, if8.Add_En, if8.Shift_En, if8.Sub_Add, if8.Busy, if8.Done};
         1: return {if16.Clear_A, if16.Load_B, if16.Add_En, if16.Shift_En, if16.Sub_Add, if16.Busy, if16.Done};
         default: return {if2.Clear_A, if2.Load_B, if2.Add_En, if2.Shift_En, if2.Sub_Add, if2.Busy, if2.Done};
      endcase
   endfunction

   task automatic drive_all();
      if8.Run  = run; if8.ClearA_LoadB  = cl; if8.M  = m; if8.Signed_Mode  = sm;
      if16.Run = run; if16.ClearA_LoadB = cl; if16.M = m; if16.Signed_Mode = sm;
      if2.Run  = run; if2.ClearA_LoadB  = cl; if2.M  = m; if2.Signed_Mode  = sm;
   endtask

   task automatic clear_stats();
      for (int k = 0; k < 3; k++) begin
         n_clr[k] = 0; n_ld[k] = 0; n_add[k] = 0; n_shift[k] = 0;
         n_sub[k] = 0; sub_at[k] = -1; first_done[k] = -1;
      end
      add_mask = '0;
   endtask

   // One clock cycle: drive, predict, compare at negedge, advance model at posedge
   task automatic tick();
      exp_t e;
      ov_t  o;
      drive_all();
      for (int k = 0; k < 3; k++) e[k] = model_out(k);
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      for (int k = 0; k < 3; k++) begin
         o = get_obs(k);
         chk($sformatf("w%0d_outputs", wid[k]), 32'(o), 32'(e[k]));
         chk($sformatf("w%0d_exclusive", wid[k]),
             32'((o[4] & o[3]) | (o[6] & (o[4] | o[3]))), 32'd0);
         if (o[6]) n_clr[k]++;
         if (o[5]) n_ld[k]++;
         if (o[4]) begin
            n_add[k]++;
            if (k == 0 && ph[0] >= 2 && ph[0] <= 16) add_mask[(ph[0] - 2) / 2] = 1'b1;
         end
         if (o[3]) n_shift[k]++;
         if (o[2]) begin
            n_sub[k]++;
            sub_at[k] = n_add[k];
         end
         if (o[0] && first_done[k] < 0) first_done[k] = tick_no - run_tick;
      end
      @(posedge clk);
      for (int k = 0; k < 3; k++) begin
         if (rst) begin
            ph[k] = 0;
            mode[k] = 1'b0;
         end else if (ph[k] == 0) begin
            if (run) begin
               ph[k] = 1;
               mode[k] = sm;
            end
         end else if (ph[k] <= 2 * wid[k] + 1) begin
            ph[k]++;
         end else if (!run) begin
            ph[k] = 0;
         end
      end
      tick_no++;
      #1;
   endtask

   initial begin
      rst = 1'b1; run = 1'b0; cl = 1'b0; m = 1'b0; sm = 1'b0;
      drive_all();
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin ph[k] = 0; mode[k] = 1'b0; end
      clear_stats();

      // Reset state, then ClearA_LoadB held in IDLE
      tick();
      rst = 1'b0;
      cl = 1'b1;
      repeat (3) tick();
      chk("idle_load_count_w8", 32'(n_ld[0]), 32'd3);
      chk("idle_clear_count_w8", 32'(n_clr[0]), 32'd3);
      cl = 1'b0;
      tick();

      // Signed, M = 1 every cycle, single Run pulse
      clear_stats();
      m = 1'b1; sm = 1'b1; run = 1'b1; run_tick = tick_no;
      tick();
      run = 1'b0; sm = 1'b0;
      repeat (40) tick();
      chk("signed_clr_w8",    32'(n_clr[0]),   32'd1);
      chk("signed_add_w8",    32'(n_add[0]),   32'd8);
      chk("signed_shift_w8",  32'(n_shift[0]), 32'd8);
      chk("signed_sub_w8",    32'(n_sub[0]),   32'd1);
      chk("signed_subat_w8",  32'(sub_at[0]),  32'd8);
      chk("latency_w8",       32'(first_done[0]), 32'd18);
      chk("signed_add_w16",   32'(n_add[1]),   32'd16);
      chk("signed_shift_w16", 32'(n_shift[1]), 32'd16);
      chk("signed_subat_w16", 32'(sub_at[1]),  32'd16);
      chk("latency_w16",      32'(first_done[1]), 32'd34);
      chk("signed_add_w2",    32'(n_add[2]),   32'd2);
      chk("latency_w2",       32'(first_done[2]), 32'd6);

      // Unsigned, M from B = 1010_0101, Signed_Mode raised after start
      clear_stats();
      sm = 1'b0; m = 1'b0; run = 1'b1; run_tick = tick_no;
      tick();
      run = 1'b0; sm = 1'b1;
      for (int i = 0; i < 40; i++) begin
         m = (ph[0] >= 2 && ph[0] <= 16 && ph[0] % 2 == 0) ? bpat[(ph[0] - 2) / 2] : 1'b0;
         tick();
      end
      chk("unsigned_mask_w8",  32'(add_mask),   32'(bpat));
      chk("unsigned_add_w8",   32'(n_add[0]),   32'd4);
      chk("unsigned_shift_w8", 32'(n_shift[0]), 32'd8);
      chk("unsigned_sub_w8",   32'(n_sub[0]),   32'd0);
      chk("unsigned_sub_w16",  32'(n_sub[1]),   32'd0);

      // Run held high for 50 cycles: exactly one multiply, HOLD persists
      clear_stats();
      m = 1'b1; sm = 1'b1; run = 1'b1; run_tick = tick_no;
      repeat (50) tick();
      chk("held_clr_w8",  32'(n_clr[0]), 32'd1);
      chk("held_add_w8",  32'(n_add[0]), 32'd8);
      chk("held_clr_w16", 32'(n_clr[1]), 32'd1);
      chk("held_done_w8", 32'(get_obs(0)), 32'h01);
      run = 1'b0;
      repeat (2) tick();

      // Second pulse with ClearA_LoadB also high; mode toggled after start
      clear_stats();
      sm = 1'b0; cl = 1'b1; run = 1'b1; run_tick = tick_no;
      tick();
      run = 1'b0; sm = 1'b1;
      repeat (3) tick();
      cl = 1'b0;
      repeat (37) tick();
      chk("second_clr_w8", 32'(n_clr[0]), 32'd1);
      chk("second_ld_w8",  32'(n_ld[0]),  32'd0);
      chk("second_ld_w2",  32'(n_ld[2]),  32'd0);
      chk("second_sub_w8", 32'(n_sub[0]), 32'd0);
      chk("second_add_w8", 32'(n_add[0]), 32'd8);

      // Reset asserted while the 8-bit unit is in ADD
      run = 1'b1; sm = 1'b1; m = 1'b1;
      tick();
      run = 1'b0;
      tick();
      chk("abort_in_add_w8", 32'(ph[0]), 32'd2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int k = 0; k < 3; k++) chk($sformatf("abort_zero_w%0d", wid[k]), 32'(get_obs(k)), 32'd0);
      clear_stats();
      repeat (5) tick();
      chk("abort_quiet_add_w8",   32'(n_add[0]),   32'd0);
      chk("abort_quiet_shift_w8", 32'(n_shift[0]), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
